// File: rtl/iter_divider_if.sv
// iter_divider_if: start/busy/done handshake and result bus of the iterative divider.
// Master (execute stage) drives start, signed_en, dividend, divisor, cancel and ack.
// Slave (divider) drives busy, done, quotient, remainder, hilo and div_by_zero.
interface iter_divider_if #(
    parameter int WIDTH = 32
);
    logic               start;
    logic               signed_en;
    logic [WIDTH-1:0]   dividend;
    logic [WIDTH-1:0]   divisor;
    logic               cancel;
    logic               ack;
    logic               busy;
    logic               done;
    logic [WIDTH-1:0]   quotient;
    logic [WIDTH-1:0]   remainder;
    logic [2*WIDTH-1:0] hilo;
    logic               div_by_zero;

    modport master (
        output start, signed_en, dividend, divisor, cancel, ack,
        input  busy, done, quotient, remainder, hilo, div_by_zero
    );

    modport slave (
        input  start, signed_en, dividend, divisor, cancel, ack,
        output busy, done, quotient, remainder, hilo, div_by_zero
    );
endinterface

// File: rtl/iter_divider.sv
// iter_divider: multi-cycle restoring divider (DIV/DIVU) with cancel and done/ack handshake.
// Ports: clk (rising edge), rst (asynchronous, active low), bus (iter_divider_if.slave):
//   start/signed_en/dividend/divisor request an operation, cancel annuls it, ack releases done;
//   busy/done report progress, quotient/remainder/hilo/div_by_zero carry the registered result.
module iter_divider #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input logic           clk,
    input logic           rst,
    iter_divider_if.slave bus
);
    typedef enum logic [2:0] {IDLE, LOAD, CALC, FIX, DONE} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, part_q, part_d, quo_q, quo_d, rem_q, rem_d;
    logic             sgn_en_q, sgn_en_d, neg_q_q, neg_q_d, neg_r_q, neg_r_d;
    logic             zero_q, zero_d, dbz_q, dbz_d, busy_q, busy_d, done_q, done_d;
    logic [WIDTH:0]   shifted, diff;
    logic             accept;

    always_comb begin
        shifted  = {part_q, a_q[WIDTH-1]};
        diff     = shifted - {1'b0, b_q};
        accept   = bus.start && !bus.cancel && (state_q == IDLE || (state_q == DONE && bus.ack));
        state_d  = state_q;
        cnt_d    = cnt_q;
        a_d      = a_q;
        b_d      = b_q;
        part_d   = part_q;
        quo_d    = quo_q;
        rem_d    = rem_q;
        sgn_en_d = sgn_en_q;
        neg_q_d  = neg_q_q;
        neg_r_d  = neg_r_q;
        zero_d   = zero_q;
        dbz_d    = dbz_q;
        if (bus.cancel) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                LOAD: begin
                    part_d  = '0;
                    cnt_d   = '0;
                    neg_q_d = sgn_en_q && (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
                    neg_r_d = sgn_en_q && a_q[WIDTH-1];
                    zero_d  = b_q == '0;
                    // A zero divisor keeps the raw dividend so FIX can return it untouched.
                    a_d     = (b_q != '0 && sgn_en_q && a_q[WIDTH-1]) ? -a_q : a_q;
                    b_d     = (sgn_en_q && b_q[WIDTH-1]) ? -b_q : b_q;
                    state_d = (b_q == '0) ? FIX : CALC;
                end
                CALC: begin
                    // diff[WIDTH] set means the trial subtraction went negative: restore.
                    a_d     = {a_q[WIDTH-2:0], ~diff[WIDTH]};
                    part_d  = diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
                    cnt_d   = cnt_q + CNT_W'(1);
                    state_d = (cnt_q == CNT_W'(WIDTH - 1)) ? FIX : CALC;
                end
                FIX: begin
                    quo_d   = zero_q ? '1 : (neg_q_q ? -a_q : a_q);
                    rem_d   = zero_q ? a_q : (neg_r_q ? -part_q : part_q);
                    dbz_d   = zero_q;
                    state_d = DONE;
                end
                DONE:    state_d = bus.ack ? IDLE : DONE;
                default: state_d = IDLE;
            endcase
        end
        if (accept) begin
            a_d      = bus.dividend;
            b_d      = bus.divisor;
            sgn_en_d = bus.signed_en;
            state_d  = LOAD;
        end
        busy_d = state_d == LOAD || state_d == CALC || state_d == FIX;
        done_d = state_d == DONE;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            part_q   <= '0;
            quo_q    <= '0;
            rem_q    <= '0;
            sgn_en_q <= 1'b0;
            neg_q_q  <= 1'b0;
            neg_r_q  <= 1'b0;
            zero_q   <= 1'b0;
            dbz_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            a_q      <= a_d;
            b_q      <= b_d;
            part_q   <= part_d;
            quo_q    <= quo_d;
            rem_q    <= rem_d;
            sgn_en_q <= sgn_en_d;
            neg_q_q  <= neg_q_d;
            neg_r_q  <= neg_r_d;
            zero_q   <= zero_d;
            dbz_q    <= dbz_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.quotient    = quo_q;
    assign bus.remainder   = rem_q;
    assign bus.hilo        = {rem_q, quo_q};
    assign bus.div_by_zero = dbz_q;
endmodule

// File: tb/tb_iter_divider.sv
// tb_iter_divider: table, random and hand-written sequence checks of iter_divider (WIDTH=32).
module tb_iter_divider;
    localparam int W = 32;

    typedef struct {
        logic         se;
        logic [W-1:0] a, b, q, r;
        logic         dbz;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   failures = 0;
    vec_t vecs[9];

    iter_divider_if #(.WIDTH(W)) bus ();
    iter_divider #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, required finish before 2000000");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", nm, act, exp);
        end
    endtask

    // {div_by_zero, remainder, quotient} from plain 64-bit arithmetic (truncating division).
    function automatic logic [2*W:0] model(input logic se, input logic [W-1:0] a, input logic [W-1:0] b);
        longint      x, y;
        logic [63:0] q, r;
        if (b == '0) return {1'b1, a, {W{1'b1}}};
        if (se) begin
            x = $signed(a);
            y = $signed(b);
        end else begin
            x = a;
            y = b;
        end
        q = x / y;
        r = x % y;
        return {1'b0, r[W-1:0], q[W-1:0]};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_op(input logic se, input logic [W-1:0] a, input logic [W-1:0] b);
        bus.start = 1'b1;
        bus.signed_en = se;
        bus.dividend = a;
        bus.divisor = b;
        tick();
        bus.start = 1'b0;
        bus.signed_en = 1'($urandom);
        bus.dividend = $urandom;
        bus.divisor = $urandom;
    endtask

    task automatic wait_done(output int n, output int nbusy);
        n = 0;
        nbusy = 0;
        while (!bus.done && n < 200) begin
            nbusy += int'(bus.busy);
            tick();
            n++;
        end
    endtask

    task automatic run_op(input string nm, input logic se, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] q, input logic [W-1:0] r, input logic dbz);
        int n, nb;
        start_op(se, a, b);
        wait_done(n, nb);
        chk({nm, " done"}, 64'(bus.done), 1);
        chk({nm, " latency"}, n, (b == '0) ? 2 : W + 2);
        chk({nm, " busy_cycles"}, nb, (b == '0) ? 2 : W + 2);
        chk({nm, " busy_with_done"}, 64'(bus.busy), 0);
        chk({nm, " quotient"}, bus.quotient, q);
        chk({nm, " remainder"}, bus.remainder, r);
        chk({nm, " hilo"}, bus.hilo, {r, q});
        chk({nm, " div_by_zero"}, 64'(bus.div_by_zero), 64'(dbz));
        bus.ack = 1'b1;
        tick();
        bus.ack = 1'b0;
        chk({nm, " done_released"}, 64'(bus.done), 0);
    endtask

    initial begin
        int           n, nb, k, rises;
        logic         se;
        logic [W-1:0] a, b;
        logic [2*W:0] e;
        bus.start = 1'b0;
        bus.signed_en = 1'b0;
        bus.dividend = '0;
        bus.divisor = '0;
        bus.cancel = 1'b0;
        bus.ack = 1'b0;
        vecs[0] = '{1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0};
        vecs[1] = '{1'b1, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0};
        vecs[2] = '{1'b0, 32'hFFFFFFF9, 32'd2, 32'h7FFFFFFC, 32'd1, 1'b0};
        vecs[3] = '{1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd0, 1'b0};
        vecs[4] = '{1'b0, 32'd55, 32'd0, 32'hFFFFFFFF, 32'd55, 1'b1};
        vecs[5] = '{1'b1, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFFD, 32'd1, 1'b0};
        vecs[6] = '{1'b0, 32'hFFFFFFFF, 32'd1, 32'hFFFFFFFF, 32'd0, 1'b0};
        vecs[7] = '{1'b1, 32'hFFFFFFF9, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFF9, 1'b1};
        vecs[8] = '{1'b0, 32'd5, 32'd9, 32'd0, 32'd5, 1'b0};

        tick();
        tick();
        chk("reset busy", 64'(bus.busy), 0);
        chk("reset done", 64'(bus.done), 0);
        chk("reset quotient", bus.quotient, 0);
        chk("reset remainder", bus.remainder, 0);
        chk("reset hilo", bus.hilo, 0);
        chk("reset div_by_zero", 64'(bus.div_by_zero), 0);
        rst = 1'b1;
        tick();

        for (int i = 0; i < 9; i++)
            run_op($sformatf("vec%0d", i), vecs[i].se, vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r, vecs[i].dbz);

        for (int i = 0; i < 40; i++) begin
            se = 1'($urandom);
            a = ($urandom_range(0, 5) == 0) ? 32'h80000000 : 32'($urandom);
            k = $urandom_range(0, 4);
            b = (k == 0) ? 32'd0 : (k == 1) ? 32'($urandom_range(1, 15)) : (k == 2) ? 32'hFFFFFFFF :
                (k == 3) ? 32'($urandom) >> $urandom_range(0, 31) : 32'($urandom);
            e = model(se, a, b);
            run_op($sformatf("rand%0d", i), se, a, b, e[W-1:0], e[2*W-1:W], e[2*W]);
        end

        // cancel during CALC: result registers keep the previous 100/7 result
        run_op("pre_cancel", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0);
        start_op(1'b0, 32'd1000, 32'd3);
        repeat (9) tick();
        bus.cancel = 1'b1;
        tick();
        bus.cancel = 1'b0;
        chk("cancel busy", 64'(bus.busy), 0);
        chk("cancel done", 64'(bus.done), 0);
        rises = 0;
        repeat (50) begin
            tick();
            rises += int'(bus.done);
        end
        chk("cancel done_never", rises, 0);
        chk("cancel quotient_kept", bus.quotient, 14);
        chk("cancel remainder_kept", bus.remainder, 2);
        chk("cancel dbz_kept", 64'(bus.div_by_zero), 0);
        bus.cancel = 1'b1;
        bus.start = 1'b1;
        bus.dividend = 32'd8;
        bus.divisor = 32'd2;
        tick();
        bus.cancel = 1'b0;
        bus.start = 1'b0;
        chk("cancel_start ignored", 64'(bus.busy), 0);
        run_op("after_cancel", 1'b0, 32'd9, 32'd3, 32'd3, 32'd0, 1'b0);

        // start while busy is ignored, done held without ack, then back-to-back ack+start
        start_op(1'b0, 32'd100, 32'd7);
        repeat (4) tick();
        bus.start = 1'b1;
        bus.dividend = 32'd77;
        bus.divisor = 32'd5;
        tick();
        bus.start = 1'b0;
        wait_done(n, nb);
        chk("hs latency", n + 5, W + 2);
        chk("hs quotient", bus.quotient, 14);
        chk("hs remainder", bus.remainder, 2);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk($sformatf("hs hold%0d done", i), 64'(bus.done), 1);
            chk($sformatf("hs hold%0d quotient", i), bus.quotient, 14);
            chk($sformatf("hs hold%0d remainder", i), bus.remainder, 2);
        end
        bus.ack = 1'b1;
        bus.start = 1'b1;
        bus.signed_en = 1'b0;
        bus.dividend = 32'd20;
        bus.divisor = 32'd6;
        tick();
        bus.ack = 1'b0;
        bus.start = 1'b0;
        chk("b2b busy", 64'(bus.busy), 1);
        chk("b2b done", 64'(bus.done), 0);
        wait_done(n, nb);
        chk("b2b latency", n, W + 2);
        chk("b2b quotient", bus.quotient, 3);
        chk("b2b remainder", bus.remainder, 2);
        bus.ack = 1'b1;
        tick();
        bus.ack = 1'b0;

        // asynchronous reset in the middle of CALC
        start_op(1'b0, 32'd1000, 32'd3);
        repeat (8) tick();
        rst = 1'b0;
        #1;
        chk("rst busy", 64'(bus.busy), 0);
        chk("rst done", 64'(bus.done), 0);
        chk("rst quotient", bus.quotient, 0);
        chk("rst remainder", bus.remainder, 0);
        chk("rst hilo", bus.hilo, 0);
        chk("rst div_by_zero", 64'(bus.div_by_zero), 0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        tick();
        chk("rst idle busy", 64'(bus.busy), 0);
        run_op("after_reset", 1'b1, 32'hFFFFFFF7, 32'd3, 32'hFFFFFFFD, 32'd0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
